// File: rtl/wbc_rr_intercon.sv
// Round-robin shared-bus WISHBONE interconnect for the wbc_clk control bus.
// Optional bus-hang watchdog is compiled in when WBC_INTERCON_TIMEOUT_EN is defined.
module wbc_rr_intercon #(
    parameter int N_MASTERS  = 4,
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int DEC_LSB    = 16,
    parameter int DEC_BITS   = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                                clk_i,
    input  logic                                rst_neg_i,
    input  logic [N_MASTERS-1:0]                m_cyc_i,
    input  logic [N_MASTERS-1:0]                m_stb_i,
    input  logic [N_MASTERS-1:0]                m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic [N_MASTERS-1:0]                m_ack_o,
    output logic [N_MASTERS-1:0]                m_err_o,
    output logic [N_MASTERS-1:0]                m_rty_o,
    output logic [N_SLAVES-1:0]                 s_cyc_o,
    output logic [N_SLAVES-1:0]                 s_stb_o,
    output logic                                s_we_o,
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    input  logic [N_SLAVES*DATA_WIDTH-1:0]      s_dat_i,
    input  logic [N_SLAVES-1:0]                 s_ack_i,
    input  logic [N_SLAVES-1:0]                 s_err_i,
    input  logic [N_SLAVES-1:0]                 s_rty_i,
    output logic [N_MASTERS-1:0]                grant_o,
    output logic                                timeout_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                state, state_next;
    logic [PTR_WIDTH-1:0]  owner, owner_next;
    logic [PTR_WIDTH-1:0]  rr_ptr, rr_ptr_next;
    logic [PTR_WIDTH-1:0]  cand;
    logic [N_MASTERS-1:0]  grant, grant_next;
    logic                  found;

    logic                  own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic [SEL_WIDTH-1:0]  own_sel;
    logic [DEC_BITS-1:0]   slave_idx;
    logic                  mapped;

    logic                  sl_ack, sl_err, sl_rty;
    logic [DATA_WIDTH-1:0] sl_dat;
    logic                  term_en;
    logic                  unmapped_err;
    logic                  timeout_hit;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        grant_next  = grant;
        found       = 1'b0;
        cand        = '0;
        case (state)
            IDLE: begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    cand = PTR_WIDTH'((int'(rr_ptr) + i) % N_MASTERS);
                    if (!found && m_cyc_i[cand]) begin
                        found      = 1'b1;
                        owner_next = cand;
                    end
                end
                if (found) begin
                    state_next = OWNED;
                    grant_next = N_MASTERS'(1) << owner_next;
                end
            end
            OWNED: begin
                // Ownership persists across strobes until the owner drops cyc.
                if (!m_cyc_i[owner]) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = PTR_WIDTH'((int'(owner) + 1) % N_MASTERS);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_neg_i) begin
        if (!rst_neg_i) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            grant        <= '0;
            unmapped_err <= 1'b0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            rr_ptr       <= rr_ptr_next;
            grant        <= grant_next;
            unmapped_err <= own_stb && !mapped && !unmapped_err;
        end
    end

    always_comb begin
        own_cyc   = (state == OWNED) && m_cyc_i[owner];
        own_stb   = own_cyc && m_stb_i[owner];
        own_we    = own_cyc && m_we_i[owner];
        own_adr   = own_cyc ? m_adr_i[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        own_dat   = own_cyc ? m_dat_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
        own_sel   = own_cyc ? m_sel_i[owner*SEL_WIDTH +: SEL_WIDTH] : '0;
        slave_idx = own_adr[DEC_LSB +: DEC_BITS];
        mapped    = int'(slave_idx) < N_SLAVES;
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        sl_ack  = 1'b0;
        sl_err  = 1'b0;
        sl_rty  = 1'b0;
        sl_dat  = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (mapped && int'(slave_idx) == s) begin
                s_cyc_o[s] = own_cyc;
                s_stb_o[s] = own_stb && !timeout_hit;
                sl_ack     = s_ack_i[s];
                sl_err     = s_err_i[s];
                sl_rty     = s_rty_i[s];
                sl_dat     = s_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A watchdog expiry suppresses slave terminations in that cycle since the slave saw no strobe.
    assign term_en = own_cyc && !timeout_hit;

    assign m_ack_o = grant & {N_MASTERS{term_en && sl_ack}};
    assign m_err_o = grant & {N_MASTERS{(term_en && !sl_ack && sl_err) || unmapped_err || timeout_hit}};
    assign m_rty_o = grant & {N_MASTERS{term_en && !sl_ack && !sl_err && sl_rty}};
    assign m_dat_o = (own_cyc && mapped) ? sl_dat : '0;

    assign s_we_o  = own_we;
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign grant_o = grant;

`ifdef WBC_INTERCON_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 any_term;

    assign any_term    = (term_en && (sl_ack || sl_err || sl_rty)) || unmapped_err;
    assign timeout_hit = own_stb && (wd_cnt == CNT_WIDTH'(TIMEOUT));
    assign timeout_o   = timeout_hit;

    always_ff @(posedge clk_i or negedge rst_neg_i) begin
        if (!rst_neg_i) begin
            wd_cnt <= '0;
        end else if (!own_stb || any_term || timeout_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: doc/wbc_rr_intercon.md
# wbc_rr_intercon

Parametrised WISHBONE control-bus interconnect for the wbc_clk domain: N masters (PCI, TURF, VIO, housekeeping) share one bus to M slaves (ID/control, LAB4 control, LAB4 RAM, spare). Replaces the fixed 4x4 shared-bus intercon with round-robin arbitration, parametrised address decode, error termination for unmapped addresses and an optional bus-hang watchdog. Shared-bus topology: one master owns the bus at a time.

## Interface
- N_MASTERS, 4, number of master ports (1-8)
- N_SLAVES, 4, number of slave ports (1-16)
- ADDR_WIDTH, 20, WISHBONE address width
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8
- DEC_LSB, 16, lowest address bit of slave decode field
- DEC_BITS, 2, width of decode field; slave index = adr[DEC_LSB +: DEC_BITS]
- TIMEOUT, 1023, watchdog limit in clk_i cycles (used only with WBC_INTERCON_TIMEOUT_EN)

- clk_i  in  1  wbc_clk; all logic on rising edge
- rst_neg_i  in  1  asynchronous, active-low reset
- m_cyc_i, m_stb_i, m_we_i  in  N_MASTERS each  master requests
- m_adr_i  in  N_MASTERS*ADDR_WIDTH  packed, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  N_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  N_MASTERS*DATA_WIDTH/8  packed byte selects
- m_dat_o  out  DATA_WIDTH  read data, common to all masters
- m_ack_o, m_err_o, m_rty_o  out  N_MASTERS each  terminations, only granted bit may be high
- s_cyc_o, s_stb_o  out  N_SLAVES each  one-hot to decoded slave
- s_we_o  out  1; s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH; s_sel_o  out  DATA_WIDTH/8  shared forwarded master signals
- s_dat_i  in  N_SLAVES*DATA_WIDTH  packed slave read data
- s_ack_i, s_err_i, s_rty_i  in  N_SLAVES each
- grant_o  out  N_MASTERS  one-hot current owner (debug)
- timeout_o  out  1  one-cycle pulse on watchdog termination

## Operation
- States: IDLE, OWNED. Reset: IDLE, grant_o=0, round-robin pointer=0, all outputs 0.
- IDLE: if any m_cyc_i, grant the first requesting master at or after pointer (wrapping modulo N_MASTERS); register grant, enter OWNED. No requests: stay IDLE.
- OWNED: owner's cyc/stb/we/adr/dat/sel forwarded to decoded slave; slave ack/err/rty and s_dat_i routed combinationally to owner. Ownership held for all strobes while owner's m_cyc_i stays high (block/RMW locking).
- Owner drops m_cyc_i: next edge -> IDLE, pointer = owner+1 mod N_MASTERS, grant cleared. One idle cycle between owners guaranteed.
- Decode: index >= N_SLAVES is unmapped: no s_cyc_o asserted; interconnect drives m_err_o for one cycle, one cycle after stb seen, then again per further strobe. m_dat_o = 0 on unmapped reads.
- Non-owner masters: ack/err/rty held 0; their stb is ignored (they wait).
- Slave asserting more than one termination: ack takes priority over err over rty.

## Timing
- Arbitration latency: m_cyc_i rising at edge 0 in IDLE -> grant registered at edge 1 -> s_cyc_o/s_stb_o valid after edge 1.
- Data/termination path: zero-cycle combinational slave->master.
- Release: cyc low sampled at edge n -> IDLE after n; new grant at n+1 earliest.
- Simultaneous requests from all masters after reset: order 0,1,2,3,0,...
- rst_neg_i low mid-transfer: all outputs 0 immediately (async), state IDLE, pointer 0; in-flight cycle abandoned.

## Configuration
- WBC_INTERCON_TIMEOUT_EN defined: counter clears on each termination or when stb low; increments while owner stb high without slave termination. On reaching TIMEOUT: m_err_o to owner and timeout_o for one cycle, s_stb_o forced low that cycle, counter cleared. Ownership unchanged.
- Undefined: no counter; timeout_o tied 0; hung slave hangs the bus until reset.

## Test plan
- Single master 0 read adr 0x10004, slave 1 acks with 0xDEADBEEF two cycles later -> s_cyc_o=4'b0010, m_ack_o[0] and m_dat_o=0xDEADBEEF same cycle as s_ack_i[1].
- Masters 0-3 request simultaneously after reset, each one write -> grants in order 0,1,2,3, one IDLE cycle between each, s_dat_o matches owner.
- Master 2 holds cyc across 3 strobes while master 0 requests -> master 0 waits until master 2 drops cyc, then granted.
- N_SLAVES=3, read 0x30000 -> no s_cyc_o, m_err_o pulse one cycle after stb, m_dat_o=0.
- WBC_INTERCON_TIMEOUT_EN, TIMEOUT=15, slave never acks -> m_err_o and timeout_o pulse 15 cycles after stb; undefined -> no err after 100 cycles.
- Assert rst_neg_i mid-burst -> all outputs 0 without clock edge; after release master 0 wins contention.
